// File: rtl/mux_key_pkg.sv
// Shared helpers for the key-matching multiplexer: table geometry.
package mux_key_pkg;

  // Width of one key/data entry in the packed lookup table.
  function automatic int unsigned pair_width(input int unsigned key_len,
                                             input int unsigned data_len);
    return key_len + data_len;
  endfunction

endpackage

// File: rtl/mux_key_comb.sv
// Combinational key match over a packed key/data table; matching entries OR
// their data, and DEFAULT is driven when no entry matches.
module mux_key_comb
  import mux_key_pkg::*;
#(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1,
  parameter logic [DATA_LEN-1:0] DEFAULT = '0
) (
  input  logic [KEY_LEN-1:0]                 key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                out,
  output logic                               hit
);

  localparam int unsigned PAIR = pair_width(KEY_LEN, DATA_LEN);

  if (NR_KEY < 1) begin : g_bad_nr_key
    $error("mux_key_comb: NR_KEY must be at least 1");
  end
  if (KEY_LEN < 1) begin : g_bad_key_len
    $error("mux_key_comb: KEY_LEN must be at least 1");
  end
  if (DATA_LEN < 1) begin : g_bad_data_len
    $error("mux_key_comb: DATA_LEN must be at least 1");
  end

  logic [NR_KEY-1:0]   match;
  logic [DATA_LEN-1:0] masked [NR_KEY];
  logic [DATA_LEN-1:0] or_acc;

  // Each entry: key in the upper KEY_LEN bits, data in the lower DATA_LEN bits.
  for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
    assign match[gi]  = (key == lut[gi*PAIR+DATA_LEN +: KEY_LEN]);
    assign masked[gi] = match[gi] ? lut[gi*PAIR +: DATA_LEN] : '0;
  end

  always_comb begin
    or_acc = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      or_acc = or_acc | masked[i];
    end
    hit = |match;
    out = hit ? or_acc : DEFAULT;
  end

endmodule

// File: rtl/mux_key.sv
// Key-matching multiplexer with a combinational result and an enable-loaded
// registered copy for pipelined users.
module mux_key
  import mux_key_pkg::*;
#(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1,
  parameter logic [DATA_LEN-1:0] DEFAULT = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  out,
  output logic                                 hit,
  output logic [DATA_LEN-1:0]                  out_q,
  output logic                                 hit_q
);

  logic [DATA_LEN-1:0] out_reg;
  logic                hit_reg;

  mux_key_comb #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN),
    .DEFAULT  (DEFAULT)
  ) u_comb (
    .key (key),
    .lut (lut),
    .out (out),
    .hit (hit)
  );

  // Reset wins over enable so a mid-stream reset always clears the copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= DEFAULT;
      hit_reg <= 1'b0;
    end else if (en) begin
      out_reg <= out;
      hit_reg <= hit;
    end
  end

  assign out_q = out_reg;
  assign hit_q = hit_reg;

endmodule

// File: tb/tb_mux_key.sv
// Self-checking bench for mux_key: several table geometries plus the
// registered path, with expected values queued at stimulus time.
module tb_mux_key;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  // Byte-lane select instance (also exercises the registered path)
  logic [1:0]  key_l = '0;
  logic [39:0] lut_l = '0;
  logic [7:0]  out_l, out_q_l;
  logic        hit_l, hit_q_l;

  // Partial table, DEFAULT 0 and DEFAULT 16'hBEEF
  logic [1:0]  key_p = '0;
  logic [53:0] lut_p = '0;
  logic [15:0] out_p0, out_q_p0, out_p1, out_q_p1;
  logic        hit_p0, hit_q_p0, hit_p1, hit_q_p1;

  // Op-code select
  logic [2:0]   key_o = '0;
  logic [174:0] lut_o = '0;
  logic [31:0]  out_o, out_q_o;
  logic         hit_o, hit_q_o;

  // Duplicate keys
  logic [1:0]  key_d = '0;
  logic [19:0] lut_d = '0;
  logic [7:0]  out_d, out_q_d;
  logic        hit_d, hit_q_d;

  mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .DEFAULT(8'h00)) u_lane (
    .clk(clk), .rst(rst), .en(en), .key(key_l), .lut(lut_l),
    .out(out_l), .hit(hit_l), .out_q(out_q_l), .hit_q(hit_q_l));

  mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16), .DEFAULT(16'h0000)) u_part0 (
    .clk(clk), .rst(rst), .en(en), .key(key_p), .lut(lut_p),
    .out(out_p0), .hit(hit_p0), .out_q(out_q_p0), .hit_q(hit_q_p0));

  mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16), .DEFAULT(16'hBEEF)) u_part1 (
    .clk(clk), .rst(rst), .en(en), .key(key_p), .lut(lut_p),
    .out(out_p1), .hit(hit_p1), .out_q(out_q_p1), .hit_q(hit_q_p1));

  mux_key #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32), .DEFAULT(32'h0)) u_op (
    .clk(clk), .rst(rst), .en(en), .key(key_o), .lut(lut_o),
    .out(out_o), .hit(hit_o), .out_q(out_q_o), .hit_q(hit_q_o));

  mux_key #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(8), .DEFAULT(8'h00)) u_dup (
    .clk(clk), .rst(rst), .en(en), .key(key_d), .lut(lut_d),
    .out(out_d), .hit(hit_d), .out_q(out_q_d), .hit_q(hit_q_d));

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data_q[$];
  logic        exp_hit_q[$];

  function automatic logic [39:0] lane_lut(input logic [31:0] w);
    return {2'b11, w[31:24], 2'b10, w[23:16], 2'b01, w[15:8], 2'b00, w[7:0]};
  endfunction

  task automatic test_reset();
    logic [31:0] ed;
    logic        eh;
    rst   = 1'b1;
    en    = 1'b0;
    lut_l = lane_lut(32'hDDCCBBAA);
    key_l = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    exp_data_q.push_back(32'h0); exp_hit_q.push_back(1'b0);
    ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    checks++;
    if ({24'h0, out_q_l} !== ed || hit_q_l !== eh) begin
      errors++;
      $display("FAIL reset_q: got out_q=%h hit_q=%b, want out_q=%h hit_q=%b", out_q_l, hit_q_l, ed[7:0], eh);
    end else $display("reset_q out_q=%h hit_q=%b", out_q_l, hit_q_l);
    // combinational path keeps following its inputs while reset is held
    checks++;
    if (out_l !== 8'hBB || hit_l !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb: got out=%h hit=%b, want out=bb hit=1", out_l, hit_l);
    end else $display("reset_comb out=%h hit=%b", out_l, hit_l);
  endtask

  task automatic test_byte_lane();
    logic [31:0] words [3] = '{32'hDDCCBBAA, 32'h12345678, 32'h00FF7F80};
    logic [31:0] ed;
    logic        eh;
    foreach (words[w]) begin
      lut_l = lane_lut(words[w]);
      for (int k = 0; k < 4; k++) begin
        key_l = 2'(k);
        exp_data_q.push_back((words[w] >> (8 * k)) & 32'hFF);
        exp_hit_q.push_back(1'b1);
        #1;
        ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
        checks++;
        if ({24'h0, out_l} !== ed || hit_l !== eh) begin
          errors++;
          $display("FAIL byte_lane: word=%h key=%0d got out=%h hit=%b, want out=%h hit=%b",
                   words[w], k, out_l, hit_l, ed[7:0], eh);
        end else $display("byte_lane word=%h key=%0d out=%h hit=%b", words[w], k, out_l, hit_l);
      end
    end
  endtask

  task automatic test_partial();
    logic [1:0]  keys  [3] = '{2'b11, 2'b01, 2'b10};
    logic [15:0] exp0  [3] = '{16'h0000, 16'h2222, 16'h3333};
    logic [15:0] exp1  [3] = '{16'hBEEF, 16'h2222, 16'h3333};
    logic        exph  [3] = '{1'b0, 1'b1, 1'b1};
    lut_p = {2'b10, 16'h3333, 2'b01, 16'h2222, 2'b00, 16'h1111};
    foreach (keys[i]) begin
      key_p = keys[i];
      #1;
      checks++;
      if (out_p0 !== exp0[i] || hit_p0 !== exph[i]) begin
        errors++;
        $display("FAIL partial_def0: key=%b got out=%h hit=%b, want out=%h hit=%b",
                 keys[i], out_p0, hit_p0, exp0[i], exph[i]);
      end else $display("partial_def0 key=%b out=%h hit=%b", keys[i], out_p0, hit_p0);
      checks++;
      if (out_p1 !== exp1[i] || hit_p1 !== exph[i]) begin
        errors++;
        $display("FAIL partial_beef: key=%b got out=%h hit=%b, want out=%h hit=%b",
                 keys[i], out_p1, hit_p1, exp1[i], exph[i]);
      end else $display("partial_beef key=%b out=%h hit=%b", keys[i], out_p1, hit_p1);
    end
  endtask

  task automatic test_opcode();
    logic [2:0]  keys [4] = '{3'b000, 3'b100, 3'b110, 3'b010};
    logic [31:0] expd [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00000000, 32'h12345680};
    logic        exph [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    lut_o = {3'b000, 32'hFFFFFF80, 3'b001, 32'h00000080, 3'b010, 32'h12345680,
             3'b100, 32'h00000080, 3'b101, 32'h00000080};
    foreach (keys[i]) begin
      key_o = keys[i];
      #1;
      checks++;
      if (out_o !== expd[i] || hit_o !== exph[i]) begin
        errors++;
        $display("FAIL opcode: key=%b got out=%h hit=%b, want out=%h hit=%b",
                 keys[i], out_o, hit_o, expd[i], exph[i]);
      end else $display("opcode key=%b out=%h hit=%b", keys[i], out_o, hit_o);
    end
  endtask

  task automatic test_duplicate();
    lut_d = {2'b01, 8'h0F, 2'b01, 8'hF0};
    key_d = 2'b01;
    #1;
    checks++;
    if (out_d !== 8'hFF || hit_d !== 1'b1) begin
      errors++;
      $display("FAIL dup_or: got out=%h hit=%b, want out=ff hit=1", out_d, hit_d);
    end else $display("dup_or key=01 out=%h hit=%b", out_d, hit_d);
    key_d = 2'b00;
    #1;
    checks++;
    if (out_d !== 8'h00 || hit_d !== 1'b0) begin
      errors++;
      $display("FAIL dup_miss: got out=%h hit=%b, want out=00 hit=0", out_d, hit_d);
    end else $display("dup_miss key=00 out=%h hit=%b", out_d, hit_d);
  endtask

  task automatic test_registered();
    logic [31:0] ed;
    logic        eh;
    lut_l = lane_lut(32'hDDCCBBAA);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; key_l = 2'd1;
    exp_data_q.push_back(32'hBB); exp_hit_q.push_back(1'b1);
    @(posedge clk); #1;
    ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    checks++;
    if ({24'h0, out_q_l} !== ed || hit_q_l !== eh) begin
      errors++;
      $display("FAIL reg_load: got out_q=%h hit_q=%b, want out_q=%h hit_q=%b", out_q_l, hit_q_l, ed[7:0], eh);
    end else $display("reg_load key=1 out_q=%h hit_q=%b", out_q_l, hit_q_l);
    @(negedge clk);
    en = 1'b0; key_l = 2'd3;
    exp_data_q.push_back(32'hBB); exp_hit_q.push_back(1'b1);
    @(posedge clk); #1;
    ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    checks++;
    if ({24'h0, out_q_l} !== ed || hit_q_l !== eh || out_l !== 8'hDD) begin
      errors++;
      $display("FAIL reg_hold: got out_q=%h hit_q=%b out=%h, want out_q=%h hit_q=%b out=dd",
               out_q_l, hit_q_l, out_l, ed[7:0], eh);
    end else $display("reg_hold key=3 out_q=%h out=%h", out_q_l, out_l);
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; key_l = 2'd2;
    @(posedge clk); #1;
    checks++;
    if (out_q_l !== 8'h00 || hit_q_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_prio: got out_q=%h hit_q=%b, want out_q=00 hit_q=0", out_q_l, hit_q_l);
    end else $display("reset_prio out_q=%h hit_q=%b", out_q_l, hit_q_l);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_q_l !== 8'hCC || hit_q_l !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got out_q=%h hit_q=%b, want out_q=cc hit_q=1", out_q_l, hit_q_l);
    end else $display("reset_release out_q=%h hit_q=%b", out_q_l, hit_q_l);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, ed;
    logic [1:0]  k;
    logic        eh;
    en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      w = $urandom;
      k = 2'($urandom_range(3, 0));
      lut_l = lane_lut(w);
      key_l = k;
      exp_data_q.push_back((w >> (8 * k)) & 32'hFF);
      exp_hit_q.push_back(1'b1);
      @(posedge clk); #1;
      ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
      checks++;
      if ({24'h0, out_q_l} !== ed || hit_q_l !== eh) begin
        errors++;
        $display("FAIL back_to_back: word=%h key=%0d got out_q=%h hit_q=%b, want out_q=%h hit_q=%b",
                 w, k, out_q_l, hit_q_l, ed[7:0], eh);
      end else $display("back_to_back word=%h key=%0d out_q=%h", w, k, out_q_l);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_lane();
    test_partial();
    test_opcode();
    test_duplicate();
    test_registered();
    test_reset_priority();
    test_back_to_back();
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_data_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
